// File: rtl/term_pkg.sv
// Shared constants, state/action types and address packing for the
// byte-stream terminal front end.
package term_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 13;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [7:0] BLANK        = 8'h20;
  localparam logic [7:0] CHR_CR       = 8'h0D;
  localparam logic [7:0] CHR_CR_HI    = 8'h8D;
  localparam logic [7:0] CHR_LF       = 8'h0A;
  localparam logic [7:0] CHR_BS       = 8'h08;
  localparam logic [7:0] CHR_ESC      = 8'h1B;
  localparam logic [7:0] CHR_LBRACKET = 8'h5B;
  localparam logic [7:0] CHR_SEMI     = 8'h3B;
  localparam logic [7:0] CHR_J        = 8'h4A;
  localparam logic [7:0] CHR_H        = 8'h48;
  localparam logic [7:0] CHR_K        = 8'h4B;

  typedef enum logic [2:0] {
    ST_GROUND     = 3'd0,
    ST_ESC        = 3'd1,
    ST_CSI        = 3'd2,
    ST_CLR_LINE   = 3'd3,
    ST_CLR_SCREEN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE       = 2'd0,
    ACT_HOME       = 2'd1,
    ACT_CLR_SCREEN = 2'd2,
    ACT_CLR_LINE   = 2'd3
  } csi_act_t;

  // Character-cell address: row and column fields side by side, no multiply.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    pack_addr = {{(ADDR_W - ROW_W - COL_W){1'b0}}, row, col};
  endfunction

  // Row increment with wrap from the last row back to row 0 (no scrolling).
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    if (row == ROW_LAST) begin
      next_row = 5'd0;
    end else begin
      next_row = row + 5'd1;
    end
  endfunction

endpackage

// File: rtl/term_if.sv
// Byte input handshake, VRAM port A write bus and cursor/status outputs.
interface term_if;
  import term_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic              busy;

  modport slave (
    input  in_valid, in_data,
    output in_ready, vram_we, vram_addr, vram_data, cur_col, cur_row, busy
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, vram_we, vram_addr, vram_data, cur_col, cur_row, busy
  );

endinterface

// File: rtl/term_csi_parser.sv
// ESC / CSI sequence tracker: decides the next escape-related state and
// accumulates the numeric parameter. The action code is a same-cycle pulse
// qualified by an accepted byte, so the writer can act on it immediately.
module term_csi_parser
  import term_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  state_t   state,
  input  logic     accept,
  input  logic [7:0] data,
  output state_t   esc_next,
  output csi_act_t act
);

  logic [6:0] p_r;
  logic [6:0] p_s;
  logic [9:0] p_acc_s;

  // Next escape state, action pulse and parameter update for the accepted byte.
  always_comb begin
    esc_next = state;
    act      = ACT_NONE;
    p_s      = p_r;
    p_acc_s  = ({3'b000, p_r} * 10'd10) + {6'b000000, data[3:0]};
    case (state)
      ST_ESC: begin
        if (accept) begin
          if (data == CHR_LBRACKET) begin
            esc_next = ST_CSI;
            p_s      = 7'd0;
          end else begin
            esc_next = ST_GROUND;
          end
        end else begin
          esc_next = ST_ESC;
        end
      end
      ST_CSI: begin
        if (accept) begin
          if (data >= 8'h30 && data <= 8'h39) begin
            esc_next = ST_CSI;
            if (p_acc_s > 10'd99) begin
              p_s = 7'd99;
            end else begin
              p_s = p_acc_s[6:0];
            end
          end else if (data == CHR_SEMI) begin
            esc_next = ST_CSI;
            p_s      = 7'd0;
          end else if (data < 8'h20) begin
            esc_next = ST_GROUND;
          end else if (data >= 8'h40 && data <= 8'h7E) begin
            esc_next = ST_GROUND;
            case (data)
              CHR_J: begin
                if (p_r == 7'd2) begin
                  act = ACT_CLR_SCREEN;
                end else begin
                  act = ACT_NONE;
                end
              end
              CHR_H:   act = ACT_HOME;
              CHR_K:   act = ACT_CLR_LINE;
              default: act = ACT_NONE;
            endcase
          end else begin
            // Intermediate bytes (0x20..0x3F other than digits/';') are skipped.
            esc_next = ST_CSI;
          end
        end else begin
          esc_next = ST_CSI;
        end
      end
      default: begin
        esc_next = state;
      end
    endcase
  end

  // Parameter accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= 7'd0;
    end else begin
      p_r <= p_s;
    end
  end

endmodule

// File: rtl/term_writer.sv
// Terminal front end: accepts UART bytes, keeps the cursor, and issues
// one character-cell write per cycle to VRAM port A, including line and
// screen clears. All outputs come straight from registers.
module term_writer
  import term_pkg::*;
(
  input  logic  clk,
  input  logic  btn_rst_n,
  term_if.slave bus
);

  state_t            state_r, state_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic [ROW_W-1:0]  row_r, row_s;
  logic [COL_W-1:0]  clr_col_r, clr_col_s;
  logic [ROW_W-1:0]  clr_row_r, clr_row_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [7:0]        data_r, data_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              accept_s;
  state_t            esc_next_s;
  csi_act_t          act_s;

  assign accept_s = bus.in_valid && ready_r;

  term_csi_parser u_csi (
    .clk      (clk),
    .rst_n    (btn_rst_n),
    .state    (state_r),
    .accept   (accept_s),
    .data     (bus.in_data),
    .esc_next (esc_next_s),
    .act      (act_s)
  );

  // Next state, cursor, clear counters and the write to issue this cycle.
  always_comb begin
    state_s   = state_r;
    col_s     = col_r;
    row_s     = row_r;
    clr_col_s = clr_col_r;
    clr_row_s = clr_row_r;
    we_s      = 1'b0;
    addr_s    = addr_r;
    data_s    = data_r;
    case (state_r)
      ST_GROUND: begin
        if (accept_s) begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            we_s   = 1'b1;
            addr_s = pack_addr(row_r, col_r);
            data_s = bus.in_data;
            if (col_r == COL_LAST) begin
              col_s     = 7'd0;
              row_s     = next_row(row_r);
              clr_row_s = next_row(row_r);
              clr_col_s = 7'd0;
              state_s   = ST_CLR_LINE;
            end else begin
              col_s = col_r + 7'd1;
            end
          end else begin
            case (bus.in_data)
              CHR_CR, CHR_CR_HI: col_s = 7'd0;
              CHR_LF: begin
                row_s     = next_row(row_r);
                clr_row_s = next_row(row_r);
                clr_col_s = 7'd0;
                state_s   = ST_CLR_LINE;
              end
              CHR_BS: begin
                if (col_r != 7'd0) begin
                  col_s  = col_r - 7'd1;
                  we_s   = 1'b1;
                  addr_s = pack_addr(row_r, col_r - 7'd1);
                  data_s = BLANK;
                end else begin
                  col_s = col_r;
                end
              end
              CHR_ESC: state_s = ST_ESC;
              default: state_s = ST_GROUND;
            endcase
          end
        end else begin
          state_s = ST_GROUND;
        end
      end
      ST_ESC, ST_CSI: begin
        if (accept_s) begin
          state_s = esc_next_s;
          case (act_s)
            ACT_HOME: begin
              col_s = 7'd0;
              row_s = 5'd0;
            end
            ACT_CLR_SCREEN: begin
              col_s     = 7'd0;
              row_s     = 5'd0;
              clr_col_s = 7'd0;
              clr_row_s = 5'd0;
              state_s   = ST_CLR_SCREEN;
            end
            ACT_CLR_LINE: begin
              clr_row_s = row_r;
              clr_col_s = 7'd0;
              state_s   = ST_CLR_LINE;
            end
            default: state_s = esc_next_s;
          endcase
        end else begin
          state_s = state_r;
        end
      end
      ST_CLR_LINE: begin
        we_s   = 1'b1;
        addr_s = pack_addr(clr_row_r, clr_col_r);
        data_s = BLANK;
        if (clr_col_r == COL_LAST) begin
          clr_col_s = 7'd0;
          state_s   = ST_GROUND;
        end else begin
          clr_col_s = clr_col_r + 7'd1;
        end
      end
      ST_CLR_SCREEN: begin
        we_s   = 1'b1;
        addr_s = pack_addr(clr_row_r, clr_col_r);
        data_s = BLANK;
        if (clr_col_r == COL_LAST) begin
          clr_col_s = 7'd0;
          if (clr_row_r == ROW_LAST) begin
            clr_row_s = 5'd0;
            state_s   = ST_GROUND;
          end else begin
            clr_row_s = clr_row_r + 5'd1;
          end
        end else begin
          clr_col_s = clr_col_r + 7'd1;
        end
      end
      default: begin
        clr_col_s = 7'd0;
        clr_row_s = 5'd0;
        state_s   = ST_CLR_SCREEN;
      end
    endcase
    ready_s = (state_s == ST_GROUND) || (state_s == ST_ESC) || (state_s == ST_CSI);
    busy_s  = (state_s == ST_CLR_LINE) || (state_s == ST_CLR_SCREEN);
  end

  // State, cursor and output registers; reset starts a full screen clear.
  always_ff @(posedge clk or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state_r   <= ST_CLR_SCREEN;
      col_r     <= 7'd0;
      row_r     <= 5'd0;
      clr_col_r <= 7'd0;
      clr_row_r <= 5'd0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      data_r    <= 8'h00;
      ready_r   <= 1'b0;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_s;
      col_r     <= col_s;
      row_r     <= row_s;
      clr_col_r <= clr_col_s;
      clr_row_r <= clr_row_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.vram_we   = we_r;
  assign bus.vram_addr = addr_r;
  assign bus.vram_data = data_r;
  assign bus.cur_col   = col_r;
  assign bus.cur_row   = row_r;
  assign bus.busy      = busy_r;

endmodule
